// File: rtl/mem_stage.sv
// mem_stage: EX->MEM register, data-SRAM completion wait, load alignment, WB and forwarding buses
module mem_stage #(
   parameter int EX_TO_MEM_WD = 79,
   parameter int MEM_TO_WB_WD = 70,
   parameter int STALL_WD     = 6
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [STALL_WD-1:0]     stall,
   input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
   input  logic [31:0]             data_sram_rdata,
   input  logic                    data_sram_data_ok,
   output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
   output logic [37:0]             mem_to_id,
   output logic                    stallreq_for_mem
);
   typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
   state_t state, state_nxt;
   logic [EX_TO_MEM_WD-1:0] r;
   logic [31:0] rbuf, src, ld_data, result;
   logic [7:0] b;
   logic [15:0] h;
   logic adv, is_load, cap, unused;
   logic [31:0] pc, ex_result;
   logic [2:0] ld_op;
   logic [3:0] ram_wen;
   logic [4:0] rf_waddr;
   logic ram_en, sel_rf_res, rf_we;
   assign {pc, ld_op, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result} = r;
   assign unused = ^{stall[2:0], stall[STALL_WD-1:5]};
   // the register changes (new op or bubble) whenever stall[4] does not freeze it too
   assign adv = ~stall[3] | ~stall[4];
   assign is_load = ram_en & ~|ram_wen;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) r <= '0;
      else if (stall[3] & ~stall[4]) r <= '0;
      else if (!stall[3]) r <= ex_to_mem_bus;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         state <= IDLE;
         rbuf  <= '0;
      end else begin
         state <= state_nxt;
         if (cap) rbuf <= data_sram_rdata;
      end
   always_comb begin
      stallreq_for_mem = ram_en & ~data_sram_data_ok & (state != HOLD);
      cap = is_load & data_sram_data_ok & ((state == WAIT) | ((state == IDLE) & stall[3]));
      state_nxt = adv ? IDLE : (state == HOLD) ? HOLD : ram_en ? (data_sram_data_ok ? HOLD : WAIT) : IDLE;
   end
   always_comb begin
      src = (data_sram_data_ok & (state != HOLD)) ? data_sram_rdata : rbuf;
      b = src[{ex_result[1:0], 3'b000} +: 8];
      h = ex_result[1] ? src[31:16] : src[15:0];
      ld_data = (ld_op == 3'd1) ? {{24{b[7]}}, b} :
                (ld_op == 3'd2) ? {24'b0, b} :
                (ld_op == 3'd3) ? {{16{h[15]}}, h} :
                (ld_op == 3'd4) ? {16'b0, h} : src;
      result = sel_rf_res ? ld_data : ex_result;
   end
   assign mem_to_wb_bus = {pc, rf_we & ~stallreq_for_mem, rf_waddr, result};
   assign mem_to_id = mem_to_wb_bus[37:0];
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a load-rule model
module tb_mem_stage;
   logic clk = 0, resetn = 0, data_ok = 0, stallreq;
   logic [5:0] stall = 0;
   logic [78:0] bus = 0;
   logic [31:0] rdata = 0;
   logic [69:0] wb;
   logic [37:0] id;
   int errs = 0, checks = 0;

   mem_stage dut (.clk(clk), .resetn(resetn), .stall(stall), .ex_to_mem_bus(bus),
      .data_sram_rdata(rdata), .data_sram_data_ok(data_ok), .mem_to_wb_bus(wb),
      .mem_to_id(id), .stallreq_for_mem(stallreq));

   always #5 clk = ~clk;

   function automatic logic [78:0] mk(input logic [31:0] pc, input logic [2:0] ld, input logic en,
      input logic [3:0] wen, input logic sel, input logic we, input logic [4:0] wa, input logic [31:0] exr);
      return {pc, ld, en, wen, sel, we, wa, exr};
   endfunction

   // load rules expressed as plain arithmetic on the word value
   function automatic logic [31:0] model_load(input logic [2:0] op, input logic [1:0] a, input logic [31:0] w);
      longint bv, hv;
      bv = (longint'(w) >> (8 * a)) % 256;
      hv = (longint'(w) >> (16 * a[1])) % 65536;
      if (op == 1) return 32'(bv >= 128 ? bv - 256 : bv);
      if (op == 2) return 32'(bv);
      if (op == 3) return 32'(hv >= 32768 ? hv - 65536 : hv);
      if (op == 4) return 32'(hv);
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      resetn = 0;
      #2;
      checks++;
      if (wb !== 0 || id !== 0 || stallreq !== 0) begin
         errs++;
         $display("FAIL reset: wb=%h id=%h stallreq=%b, required all 0", wb, id, stallreq);
      end
      @(negedge clk);
      resetn = 1;
      tick();
   endtask

   task automatic test_lw();
      bus = mk(32'h40, 3'd0, 1, 4'd0, 1, 1, 5'd5, 32'h100);
      tick();
      bus = 0; data_ok = 1; rdata = 32'h12345678;
      @(negedge clk);
      checks++;
      if (stallreq !== 0 || wb !== {32'h40, 1'b1, 5'd5, 32'h12345678} || id !== {1'b1, 5'd5, 32'h12345678}) begin
         errs++;
         $display("FAIL lw_first_cycle: stallreq=%b wb=%h id=%h, required 0 %h", stallreq, wb, id,
            {32'h40, 1'b1, 5'd5, 32'h12345678});
      end
      tick();
      data_ok = 0;
   endtask

   task automatic test_align();
      logic [2:0] ops [4] = '{3'd1, 3'd2, 3'd4, 3'd3};
      logic [31:0] addr [4] = '{32'h203, 32'h203, 32'h202, 32'h202};
      logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'h000080AA, 32'hFFFF80AA};
      for (int i = 0; i < 4; i++) begin
         bus = mk(32'h80 + i, ops[i], 1, 4'd0, 1, 1, 5'd9, addr[i]);
         tick();
         bus = 0; data_ok = 1; rdata = 32'h80AABBCC;
         @(negedge clk);
         checks++;
         if (wb[31:0] !== exp[i] || stallreq !== 0) begin
            errs++;
            $display("FAIL align_%0d: result=%h stallreq=%b, required %h 0", i, wb[31:0], stallreq, exp[i]);
         end
         tick();
         data_ok = 0;
      end
   endtask

   task automatic test_wait();
      bus = mk(32'hC0, 3'd0, 1, 4'd0, 1, 1, 5'd3, 32'h300);
      tick();
      for (int k = 0; k < 3; k++) begin
         bus = $urandom; data_ok = (k == 2); rdata = (k == 2) ? 32'hA5A55A5A : $urandom;
         stall = (k < 2) ? 6'h1f : 6'h00;
         @(negedge clk);
         checks++;
         if (k < 2 && (stallreq !== 1 || wb[37] !== 0 || id[37] !== 0)) begin
            errs++;
            $display("FAIL wait_stall_%0d: stallreq=%b wb_we=%b id_we=%b, required 1 0 0", k, stallreq, wb[37], id[37]);
         end
         if (k == 2 && (stallreq !== 0 || wb !== {32'hC0, 1'b1, 5'd3, 32'hA5A55A5A} || id !== wb[37:0])) begin
            errs++;
            $display("FAIL wait_done: stallreq=%b wb=%h id=%h, required 0 %h", stallreq, wb, id,
               {32'hC0, 1'b1, 5'd3, 32'hA5A55A5A});
         end
         if (k == 2) bus = 0;
         tick();
      end
      data_ok = 0; stall = 0;
   endtask

   task automatic test_hold();
      bus = mk(32'h140, 3'd0, 1, 4'd0, 1, 1, 5'd11, 32'h400);
      tick();
      for (int k = 0; k < 4; k++) begin
         bus = $urandom; stall = (k < 3) ? 6'h1f : 6'h00;
         data_ok = (k >= 1); rdata = (k == 1) ? 32'hCAFE1234 : 32'hDEADBEEF;
         @(negedge clk);
         if (k >= 1) begin
            checks++;
            if (stallreq !== 0 || wb !== {32'h140, 1'b1, 5'd11, 32'hCAFE1234}) begin
               errs++;
               $display("FAIL hold_%0d: stallreq=%b wb=%h, required 0 %h", k, stallreq, wb,
                  {32'h140, 1'b1, 5'd11, 32'hCAFE1234});
            end
         end
         if (k == 3) bus = 0;
         tick();
      end
      data_ok = 0; stall = 0;
   endtask

   task automatic test_bubble();
      logic [69:0] exp;
      exp = {32'h1C0, 1'b1, 5'd7, 32'h77778888};
      bus = mk(32'h1C0, 3'd0, 0, 4'd0, 0, 1, 5'd7, 32'h77778888);
      tick();
      bus = $urandom; stall = 6'b011000;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checks++;
         if (wb !== exp || id !== exp[37:0]) begin
            errs++;
            $display("FAIL bubble_hold_%0d: wb=%h id=%h, required %h", k, wb, id, exp);
         end
         tick();
         if (k == 0) stall = 6'b001000;
      end
      @(negedge clk);
      checks++;
      if (wb !== 0 || id !== 0 || stallreq !== 0) begin
         errs++;
         $display("FAIL bubble_clear: wb=%h id=%h stallreq=%b, required all 0", wb, id, stallreq);
      end
      stall = 0; bus = 0;
      tick();
   endtask

   task automatic test_async_reset();
      bus = mk(32'h200, 3'd0, 1, 4'd0, 1, 1, 5'd13, 32'h500);
      tick();
      bus = 0; stall = 6'h1f; data_ok = 0;
      @(negedge clk);
      checks++;
      if (stallreq !== 1) begin
         errs++;
         $display("FAIL areset_pre: stallreq=%b, required 1", stallreq);
      end
      tick();
      #2 resetn = 0;
      #1;
      checks++;
      if (wb !== 0 || id !== 0 || stallreq !== 0) begin
         errs++;
         $display("FAIL areset_now: wb=%h id=%h stallreq=%b, required all 0", wb, id, stallreq);
      end
      @(negedge clk);
      resetn = 1; stall = 0;
      tick();
      data_ok = 1; rdata = 32'h5555AAAA;
      @(negedge clk);
      checks++;
      if (wb !== 0 || stallreq !== 0) begin
         errs++;
         $display("FAIL areset_stray: wb=%h stallreq=%b, required 0 0", wb, stallreq);
      end
      tick();
      data_ok = 0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         logic [31:0] pc, exr, dat, cur;
         logic [2:0] ld;
         logic en, sel, we, st, exp_sr;
         logic [3:0] wen;
         logic [4:0] wa;
         int lat;
         pc = $urandom; exr = $urandom; dat = $urandom; ld = 3'($urandom_range(0, 7));
         en = ($urandom_range(0, 3) != 0); st = en && $urandom_range(0, 1);
         wen = st ? 4'($urandom_range(1, 15)) : 4'd0;
         sel = en ? 1'($urandom_range(0, 1)) : 1'b0;
         we = 1'($urandom_range(0, 1)); wa = 5'($urandom);
         lat = en ? $urandom_range(0, 3) : 0;
         bus = mk(pc, ld, en, wen, sel, we, wa, exr); stall = 0; data_ok = 0;
         tick();
         for (int k = 0; k <= lat; k++) begin
            cur = (k == lat) ? dat : $urandom;
            bus = (k == lat) ? 79'd0 : {$urandom, $urandom, 15'($urandom)};
            rdata = cur; data_ok = en && (k == lat); stall = (k < lat) ? 6'h1f : 6'h00;
            exp_sr = en && (k < lat);
            @(negedge clk);
            checks++;
            if (stallreq !== exp_sr || wb[69:32] !== {pc, we & ~exp_sr, wa} || id !== wb[37:0] ||
                (!exp_sr && wb[31:0] !== (sel ? model_load(ld, exr[1:0], cur) : exr))) begin
               errs++;
               $display("FAIL random_%0d_%0d: stallreq=%b wb=%h, required %b %h", n, k, stallreq, wb, exp_sr,
                  {pc, we & ~exp_sr, wa, sel ? model_load(ld, exr[1:0], cur) : exr});
            end
            tick();
         end
         data_ok = 0;
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_align();
      test_wait();
      test_hold();
      test_bubble();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
